// File: rtl/l1_mra_arbiter.sv
// Round-robin arbiter from NUM_CLIENTS L1/tile-control request FIFOs onto a single MRA port,
// with read throttling and in-order response routing back to the issuing client.
module l1_mra_arbiter #(
    parameter int unsigned DATA_WIDTH      = 512,
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned NUM_CLIENTS     = 4,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]    cl_req_addr,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0]    cl_req_data,
    input  logic [NUM_CLIENTS-1:0]               cl_req_rw,
    input  logic [NUM_CLIENTS-1:0]               cl_req_valid,
    output logic [NUM_CLIENTS-1:0]               cl_req_ready,
    output logic [DATA_WIDTH-1:0]                cl_rsp_data,
    output logic [NUM_CLIENTS-1:0]               cl_rsp_valid,
    output logic [ADDR_WIDTH-1:0]                mra_req_addr,
    output logic [DATA_WIDTH-1:0]                mra_req_data,
    output logic                                 mra_req_rw,
    output logic                                 mra_req_valid,
    input  logic                                 mra_req_ready,
    input  logic [DATA_WIDTH-1:0]                mra_rsp_data,
    input  logic                                 mra_rsp_valid,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_cnt,
    output logic                                 rsp_err
);

    localparam int unsigned IDW = $clog2(NUM_CLIENTS);
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned RW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [ADDR_WIDTH-1:0] r_q_addr [NUM_CLIENTS][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_q_data [NUM_CLIENTS][FIFO_DEPTH];
    logic                  r_q_rw   [NUM_CLIENTS][FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr [NUM_CLIENTS];
    logic [PW-1:0]         r_rd_ptr [NUM_CLIENTS];
    logic [CW-1:0]         r_cnt    [NUM_CLIENTS];

    logic                  r_out_valid;
    logic [ADDR_WIDTH-1:0] r_out_addr;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_rw;
    logic [IDW-1:0]        r_out_id;
    logic [IDW-1:0]        r_last_grant;

    logic [IDW-1:0]        r_route [MAX_OUTSTANDING];
    logic [RW-1:0]         r_rt_wr;
    logic [RW-1:0]         r_rt_rd;
    logic [OW-1:0]         r_os_cnt;
    logic [NUM_CLIENTS-1:0] r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_err;

    logic [NUM_CLIENTS-1:0] w_push;
    logic [NUM_CLIENTS-1:0] w_pop;
    logic [NUM_CLIENTS-1:0] w_elig;
    logic [NUM_CLIENTS-1:0] w_head_rw;
    logic [OW:0]            w_inflight;
    logic                   w_rd_ok;
    logic                   w_any;
    logic [IDW-1:0]         w_grant;
    logic                   w_load;
    logic                   w_issue_rd;
    logic                   w_rsp_acc;

    function automatic logic [RW-1:0] rt_next(input logic [RW-1:0] p);
        if (32'(p) == MAX_OUTSTANDING - 1) return '0;
        return p + 1'b1;
    endfunction

    // Reads parked in the output register already count against the outstanding budget.
    always_comb begin
        w_inflight = {1'b0, r_os_cnt} + {{OW{1'b0}}, (r_out_valid && !r_out_rw)};
        w_rd_ok    = w_inflight < (OW+1)'(MAX_OUTSTANDING);
    end

    always_comb begin
        w_head_rw    = '0;
        cl_req_ready = '0;
        w_push       = '0;
        w_elig       = '0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            w_head_rw[i]    = r_q_rw[i][r_rd_ptr[i]];
            cl_req_ready[i] = rst_n && (r_cnt[i] != CW'(FIFO_DEPTH));
            w_push[i]       = cl_req_valid[i] && cl_req_ready[i];
            w_elig[i]       = (r_cnt[i] != '0) && (w_head_rw[i] || w_rd_ok);
        end
    end

    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
            if (!w_any && w_elig[IDW'((32'(r_last_grant) + 1 + k) % NUM_CLIENTS)]) begin
                w_any   = 1'b1;
                w_grant = IDW'((32'(r_last_grant) + 1 + k) % NUM_CLIENTS);
            end
        end
        w_load = w_any && (!r_out_valid || mra_req_ready);
        w_pop  = '0;
        if (w_load) w_pop[w_grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_cnt[i]    <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
                if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
                if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
                if (w_push[i] && !w_pop[i])      r_cnt[i] <= r_cnt[i] + 1'b1;
                else if (!w_push[i] && w_pop[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            if (w_push[i]) begin
                r_q_addr[i][r_wr_ptr[i]] <= cl_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                r_q_data[i][r_wr_ptr[i]] <= cl_req_data[i*DATA_WIDTH +: DATA_WIDTH];
                r_q_rw[i][r_wr_ptr[i]]   <= cl_req_rw[i];
            end
        end
    end

    // Output register only reloads when empty or draining, so a stalled payload never changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_addr   <= '0;
            r_out_data   <= '0;
            r_out_rw     <= 1'b0;
            r_out_id     <= '0;
            r_last_grant <= IDW'(NUM_CLIENTS - 1);
        end else if (w_load) begin
            r_out_valid  <= 1'b1;
            r_out_addr   <= r_q_addr[w_grant][r_rd_ptr[w_grant]];
            r_out_data   <= r_q_data[w_grant][r_rd_ptr[w_grant]];
            r_out_rw     <= r_q_rw[w_grant][r_rd_ptr[w_grant]];
            r_out_id     <= w_grant;
            r_last_grant <= w_grant;
        end else if (mra_req_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign w_issue_rd = r_out_valid && mra_req_ready && !r_out_rw;
    assign w_rsp_acc  = mra_rsp_valid && (r_os_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rt_wr     <= '0;
            r_rt_rd     <= '0;
            r_os_cnt    <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_issue_rd) r_rt_wr <= rt_next(r_rt_wr);
            if (w_rsp_acc)  r_rt_rd <= rt_next(r_rt_rd);
            if (w_issue_rd && !w_rsp_acc)      r_os_cnt <= r_os_cnt + 1'b1;
            else if (!w_issue_rd && w_rsp_acc) r_os_cnt <= r_os_cnt - 1'b1;
            r_rsp_valid <= w_rsp_acc ? (NUM_CLIENTS'(1) << r_route[r_rt_rd]) : '0;
            if (w_rsp_acc) r_rsp_data <= mra_rsp_data;
            if (mra_rsp_valid && (r_os_cnt == '0)) r_rsp_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue_rd) r_route[r_rt_wr] <= r_out_id;
    end

    assign mra_req_valid   = r_out_valid;
    assign mra_req_addr    = r_out_addr;
    assign mra_req_data    = r_out_data;
    assign mra_req_rw      = r_out_rw;
    assign cl_rsp_valid    = r_rsp_valid;
    assign cl_rsp_data     = r_rsp_data;
    assign outstanding_cnt = r_os_cnt;
    assign rsp_err         = r_rsp_err;

endmodule

// File: tb/tb_l1_mra_arbiter.sv
// Directed bench for l1_mra_arbiter: arbitration order, read throttle, stall stability,
// response routing, orphan responses and asynchronous reset.
module tb_l1_mra_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;

    logic              clk;
    logic              rst_n;
    logic [N*AW-1:0]   cl_req_addr;
    logic [N*DW-1:0]   cl_req_data;
    logic [N-1:0]      cl_req_rw;
    logic [N-1:0]      cl_req_valid;
    logic [N-1:0]      cl_req_ready;
    logic [DW-1:0]     cl_rsp_data;
    logic [N-1:0]      cl_rsp_valid;
    logic [AW-1:0]     mra_req_addr;
    logic [DW-1:0]     mra_req_data;
    logic              mra_req_rw;
    logic              mra_req_valid;
    logic              mra_req_ready;
    logic [DW-1:0]     mra_rsp_data;
    logic              mra_rsp_valid;
    logic [3:0]        outstanding_cnt;
    logic              rsp_err;

    int n_checks = 0;
    int n_fail   = 0;
    int pushed;
    int issued;
    int hs;

    l1_mra_arbiter #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .NUM_CLIENTS     (N),
        .FIFO_DEPTH      (2),
        .MAX_OUTSTANDING (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cl_req_addr     (cl_req_addr),
        .cl_req_data     (cl_req_data),
        .cl_req_rw       (cl_req_rw),
        .cl_req_valid    (cl_req_valid),
        .cl_req_ready    (cl_req_ready),
        .cl_rsp_data     (cl_rsp_data),
        .cl_rsp_valid    (cl_rsp_valid),
        .mra_req_addr    (mra_req_addr),
        .mra_req_data    (mra_req_data),
        .mra_req_rw      (mra_req_rw),
        .mra_req_valid   (mra_req_valid),
        .mra_req_ready   (mra_req_ready),
        .mra_rsp_data    (mra_rsp_data),
        .mra_rsp_valid   (mra_rsp_valid),
        .outstanding_cnt (outstanding_cnt),
        .rsp_err         (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b1;
        cl_req_addr   = '0;
        cl_req_data   = '0;
        cl_req_rw     = '0;
        cl_req_valid  = '0;
        mra_req_ready = 1'b0;
        mra_rsp_data  = '0;
        mra_rsp_valid = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_ready",   64'(cl_req_ready), 64'h0);
        chk("rst_valid",   64'(mra_req_valid), 64'h0);
        chk("rst_cnt",     64'(outstanding_cnt), 64'h0);
        chk("rst_err",     64'(rsp_err), 64'h0);
        chk("rst_rspv",    64'(cl_rsp_valid), 64'h0);
        #20 rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 64'(cl_req_ready), 64'hF);

        // All four clients read in the same cycle: issue order 0,1,2,3, first valid at t+2.
        mra_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) cl_req_addr[i*AW +: AW] = 16'h100 + 16'(i);
        cl_req_valid = 4'hF;
        tick();
        cl_req_valid = 4'h0;
        chk("a_lat_t1", 64'(mra_req_valid), 64'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("a_valid", 64'(mra_req_valid), 64'h1);
            chk("a_order", 64'(mra_req_addr), 64'h100 + 64'(i));
        end
        tick();
        chk("a_idle", 64'(mra_req_valid), 64'h0);
        chk("a_cnt4", 64'(outstanding_cnt), 64'h4);
        for (int i = 0; i < 4; i++) begin
            mra_rsp_valid = 1'b1;
            mra_rsp_data  = 32'hA0 + 32'(i);
            tick();
            chk("a_rsp_route", 64'(cl_rsp_valid), 64'(4'b0001 << i));
            chk("a_rsp_data",  64'(cl_rsp_data), 64'hA0 + 64'(i));
        end
        mra_rsp_valid = 1'b0;
        tick();
        chk("a_rsp_idle", 64'(cl_rsp_valid), 64'h0);
        chk("a_cnt0",     64'(outstanding_cnt), 64'h0);

        // Client 2 streams nine reads with no responses: eight issue, ninth is throttled.
        pushed = 0;
        issued = 0;
        cl_req_rw = 4'h0;
        for (int c = 0; c < 40; c++) begin
            if (pushed < 9) begin
                cl_req_valid = 4'b0100;
                cl_req_addr[2*AW +: AW] = 16'h200 + 16'(pushed);
            end else begin
                cl_req_valid = 4'h0;
            end
            if (mra_req_valid && mra_req_ready) begin
                chk("b_issue_addr", 64'(mra_req_addr), 64'h200 + 64'(issued));
                issued++;
            end
            if (cl_req_valid[2] && cl_req_ready[2]) pushed++;
            tick();
        end
        cl_req_valid = 4'h0;
        chk("b_pushed", 64'(pushed), 64'd9);
        chk("b_issued", 64'(issued), 64'd8);
        chk("b_cnt8",   64'(outstanding_cnt), 64'h8);
        chk("b_held",   64'(mra_req_valid), 64'h0);
        mra_rsp_valid = 1'b1;
        mra_rsp_data  = 32'hB0;
        tick();
        mra_rsp_valid = 1'b0;
        chk("b_rsp1_route", 64'(cl_rsp_valid), 64'h4);
        chk("b_cnt7",       64'(outstanding_cnt), 64'h7);
        tick();
        chk("b_9th_valid", 64'(mra_req_valid), 64'h1);
        chk("b_9th_addr",  64'(mra_req_addr), 64'h208);
        tick();
        chk("b_cnt8_again", 64'(outstanding_cnt), 64'h8);
        chk("b_9th_gone",   64'(mra_req_valid), 64'h0);
        for (int i = 0; i < 8; i++) begin
            mra_rsp_valid = 1'b1;
            tick();
            chk("b_drain_route", 64'(cl_rsp_valid), 64'h4);
        end
        mra_rsp_valid = 1'b0;
        tick();
        chk("b_cnt0", 64'(outstanding_cnt), 64'h0);

        // Write to 0x40 stalled five cycles: payload holds, exactly one handshake.
        mra_req_ready = 1'b0;
        cl_req_valid  = 4'b0001;
        cl_req_rw     = 4'b0001;
        cl_req_addr[0 +: AW] = 16'h0040;
        cl_req_data[0 +: DW] = 32'hDEAD_BEEF;
        tick();
        cl_req_valid = 4'h0;
        tick();
        hs = 0;
        for (int k = 0; k < 5; k++) begin
            chk("c_valid", 64'(mra_req_valid), 64'h1);
            chk("c_addr",  64'(mra_req_addr), 64'h40);
            chk("c_data",  64'(mra_req_data), 64'hDEAD_BEEF);
            chk("c_rw",    64'(mra_req_rw), 64'h1);
            if (mra_req_valid && mra_req_ready) hs++;
            tick();
        end
        mra_req_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (mra_req_valid && mra_req_ready) hs++;
            tick();
        end
        chk("c_one_hs", 64'(hs), 64'd1);
        chk("c_wr_cnt", 64'(outstanding_cnt), 64'h0);
        chk("c_no_rsp", 64'(cl_rsp_valid), 64'h0);
        cl_req_rw = 4'h0;

        // Reads from clients 1 and 3, responses routed back in issue order.
        cl_req_valid = 4'b0010;
        cl_req_addr[1*AW +: AW] = 16'h0311;
        tick();
        cl_req_valid = 4'b1000;
        cl_req_addr[3*AW +: AW] = 16'h0333;
        tick();
        cl_req_valid = 4'h0;
        tick();
        tick();
        tick();
        chk("d_cnt2", 64'(outstanding_cnt), 64'h2);
        mra_rsp_valid = 1'b1;
        mra_rsp_data  = 32'h1111_0000;
        tick();
        chk("d_rsp0_route", 64'(cl_rsp_valid), 64'h2);
        chk("d_rsp0_data",  64'(cl_rsp_data), 64'h1111_0000);
        mra_rsp_data = 32'h2222_0001;
        tick();
        chk("d_rsp1_route", 64'(cl_rsp_valid), 64'h8);
        chk("d_rsp1_data",  64'(cl_rsp_data), 64'h2222_0001);
        mra_rsp_valid = 1'b0;
        tick();
        chk("d_rsp_pulse", 64'(cl_rsp_valid), 64'h0);
        chk("d_cnt0",      64'(outstanding_cnt), 64'h0);

        // Orphan response with nothing outstanding.
        mra_rsp_valid = 1'b1;
        mra_rsp_data  = 32'h55;
        tick();
        mra_rsp_valid = 1'b0;
        chk("e_err",     64'(rsp_err), 64'h1);
        chk("e_no_rsp",  64'(cl_rsp_valid), 64'h0);
        chk("e_cnt0",    64'(outstanding_cnt), 64'h0);
        tick();
        chk("e_sticky",  64'(rsp_err), 64'h1);

        // Reset in the middle of traffic.
        cl_req_valid = 4'b0011;
        tick();
        cl_req_valid = 4'h0;
        tick();
        tick();
        tick();
        chk("f_pre_cnt2", 64'(outstanding_cnt), 64'h2);
        mra_req_ready = 1'b0;
        cl_req_valid  = 4'b0001;
        cl_req_addr[0 +: AW] = 16'h0077;
        tick();
        cl_req_valid = 4'h0;
        tick();
        chk("f_pre_valid", 64'(mra_req_valid), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("f_rst_valid", 64'(mra_req_valid), 64'h0);
        chk("f_rst_ready", 64'(cl_req_ready), 64'h0);
        chk("f_rst_cnt",   64'(outstanding_cnt), 64'h0);
        chk("f_rst_err",   64'(rsp_err), 64'h0);
        chk("f_rst_rspv",  64'(cl_rsp_valid), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("f_resume_ready", 64'(cl_req_ready), 64'hF);
        chk("f_discarded",    64'(mra_req_valid), 64'h0);
        mra_req_ready = 1'b1;
        mra_rsp_valid = 1'b1;
        tick();
        mra_rsp_valid = 1'b0;
        chk("f_orphan_err",  64'(rsp_err), 64'h1);
        chk("f_orphan_rspv", 64'(cl_rsp_valid), 64'h0);
        chk("f_orphan_cnt",  64'(outstanding_cnt), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
